// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and the multiply/divide sequencer types.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MULT = 4'b0010;
  localparam logic [3:0] ALU_DIV  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_e;

  typedef enum logic {
    MODE_MUL,
    MODE_DIV
  } muldiv_mode_e;

endpackage

// File: rtl/muldiv_step.sv
// One unsigned iteration of shift-add multiply or restoring divide on a
// (2*WIDTH+1)-bit accumulator; the extra top bit holds the multiply carry.
module muldiv_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  muldiv_mode_e         mode,
  input  logic [2*WIDTH:0]     acc,
  input  logic [WIDTH-1:0]     mag,
  output logic [2*WIDTH:0]     acc_next
);

  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH:0] div_shift;
  logic [WIDTH:0]   div_rem;
  logic             div_fit;

  always_comb begin
    // Multiply: {upper, multiplier}; add multiplicand on LSB, then shift right.
    mul_sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mag} : '0);
    // Divide: {remainder, quotient}; shift left, then trial-subtract.
    div_shift = {acc[2*WIDTH-1:0], 1'b0};
    div_rem   = div_shift[2*WIDTH:WIDTH];
    div_fit   = (div_rem >= {1'b0, mag});
    if (mode == MODE_MUL) begin
      acc_next = {1'b0, mul_sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {(div_fit ? (div_rem - {1'b0, mag}) : div_rem),
                  div_shift[WIDTH-1:1], div_fit};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply / divide sequencer writing HI and LO.
// Operands are reduced to magnitudes on start; signs are reapplied when the result lands.
module muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [3:0]              ALU_control,
  input  logic signed [WIDTH-1:0] operand_a,
  input  logic signed [WIDTH-1:0] operand_b,
  output logic                    busy,
  output logic                    done,
  output logic                    div_by_zero,
  output logic [WIDTH-1:0]        hi,
  output logic [WIDTH-1:0]        lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int ACC_W = 2 * WIDTH + 1;

  muldiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] acc_q, acc_step;
  logic [WIDTH-1:0] mag_q;
  logic             res_neg_q, dvd_neg_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             dbz_q;

  logic             capture, div_zero, finish, iterating, last_iter;
  muldiv_mode_e     step_mode;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot, rem;
  logic [WIDTH-1:0] res_hi, res_lo;

  // -2^(WIDTH-1) has no positive signed form but maps cleanly to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] mag_of(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return v[WIDTH-1] ? -u : u;
  endfunction

  assign iterating = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign step_mode = (state_q == ST_MUL) ? MODE_MUL : MODE_DIV;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode     (step_mode),
    .acc      (acc_q),
    .mag      (mag_q),
    .acc_next (acc_step)
  );

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    div_zero = 1'b0;
    finish   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (ALU_control == ALU_MULT) begin
            state_d = ST_MUL;
            capture = 1'b1;
          end else if (ALU_control == ALU_DIV) begin
            if (operand_b == '0) begin
              state_d  = ST_DONE;
              div_zero = 1'b1;
            end else begin
              state_d = ST_DIV;
              capture = 1'b1;
            end
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (last_iter) begin
          state_d = ST_DONE;
          finish  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sign fix-up on the final iteration's accumulator
  always_comb begin
    prod = acc_step[2*WIDTH-1:0];
    quot = acc_step[WIDTH-1:0];
    rem  = acc_step[2*WIDTH-1:WIDTH];
    if (state_q == ST_MUL) begin
      {res_hi, res_lo} = res_neg_q ? -prod : prod;
    end else begin
      res_lo = res_neg_q ? -quot : quot;
      res_hi = dvd_neg_q ? -rem : rem;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        cnt_q <= '0;
      end else if (iterating) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (div_zero) begin
        hi_q  <= operand_a;
        lo_q  <= '1;
        dbz_q <= 1'b1;
      end else if (finish) begin
        hi_q  <= res_hi;
        lo_q  <= res_lo;
        dbz_q <= 1'b0;
      end else if (state_q == ST_DONE) begin
        dbz_q <= 1'b0;
      end
    end
  end

  // Datapath registers: only meaningful after a capture, so no reset needed.
  always_ff @(posedge clk) begin
    if (capture) begin
      res_neg_q <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
      dvd_neg_q <= operand_a[WIDTH-1];
      if (state_d == ST_MUL) begin
        acc_q <= ACC_W'(mag_of(operand_b));
        mag_q <= mag_of(operand_a);
      end else begin
        acc_q <= ACC_W'(mag_of(operand_a));
        mag_q <= mag_of(operand_b);
      end
    end else if (iterating) begin
      acc_q <= acc_step;
    end
  end

  assign busy        = iterating;
  assign done        = (state_q == ST_DONE);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: 64-bit arithmetic reference model,
// expected results queued at issue and popped by a monitor on each done.
module tb_muldiv_sequencer;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] a, b;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ALU_control (alu_ctrl),
    .operand_a   (a),
    .operand_b   (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (dbz),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: full-width signed arithmetic, truncating division.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] oa, input logic [W-1:0] ob);
    exp_t        e;
    longint      sa, sb, p, q, r;
    logic [63:0] pv, qv, rv;
    sa = longint'($signed(oa));
    sb = longint'($signed(ob));
    e  = '0;
    if (op == ALU_MULT) begin
      p  = sa * sb;
      pv = p;
      e.hi = pv[63:32];
      e.lo = pv[31:0];
    end else if (ob == '0) begin
      e.hi  = oa;
      e.lo  = '1;
      e.dbz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      qv = q;
      rv = r;
      e.lo = qv[31:0];
      e.hi = rv[31:0];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got hi=%h lo=%h with no operation pending", hi, lo);
      end else begin
        e = sb_q.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("div_by_zero", 64'(dbz), 64'(e.dbz));
      end
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input bit glitch);
    exp_t e;
    int   lat, bcnt, exp_lat;
    e       = model(op, oa, ob);
    exp_lat = (op == ALU_DIV && ob == '0) ? 1 : W + 1;
    @(negedge clk);
    alu_ctrl = op; a = oa; b = ob; start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0; a = $urandom; b = $urandom;
    lat = 0; bcnt = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (glitch && lat == 5) begin
        start = 1'b1; alu_ctrl = ALU_MULT; a = $urandom; b = $urandom;
      end
      if (glitch && lat == 6) start = 1'b0;
      if (done) break;
    end
    start = 1'b0;
    check("latency", 64'(lat), 64'(exp_lat));
    check("busy_cycles", 64'(bcnt), 64'(exp_lat - 1));
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  task automatic ignored_op();
    bit seen;
    @(negedge clk);
    alu_ctrl = ALU_ADD; a = $urandom; b = $urandom; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done) seen = 1'b1;
    end
    check("ignored_activity", 64'(seen), 64'(0));
    check("ignored_hold_hi", 64'(hi), 64'(last_hi));
    check("ignored_hold_lo", 64'(lo), 64'(last_lo));
  endtask

  task automatic reset_mid_div();
    @(negedge clk);
    alu_ctrl = ALU_DIV; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dbz", 64'(dbz), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_hi = '0;
    last_lo = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required completion in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    reset = 1'b1; start = 1'b0; alu_ctrl = ALU_ADD; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_dbz", 64'(dbz), 64'(0));
    reset = 1'b0;

    do_op(ALU_MULT, 32'd7, -32'sd3, 1'b0);
    do_op(ALU_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op(ALU_MULT, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(ALU_DIV, 32'd7, -32'sd2, 1'b0);
    do_op(ALU_DIV, -32'sd7, 32'd2, 1'b0);
    do_op(ALU_DIV, 32'd5, 32'd0, 1'b0);
    ignored_op();
    do_op(ALU_MULT, 32'd12345, -32'sd678, 1'b1);
    reset_mid_div();
    do_op(ALU_MULT, 32'd3, 32'd4, 1'b0);
    do_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(ALU_DIV, 32'h8000_0000, 32'h8000_0000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = W'($urandom_range(1, 20));
        4: ra = W'($urandom_range(0, 50));
        default: ;
      endcase
      do_op(($urandom_range(0, 1) == 0) ? ALU_MULT : ALU_DIV, ra, rb, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the ALU's multiply (ALU_control 4'b0010) and divide (ALU_control 4'b0011) operations. The single-cycle ALU handles add/sub/logic/shift. This block runs a signed iterative shift-add multiply or restoring divide over WIDTH cycles and writes the HI/LO result registers. It raises busy so the pipeline control can stall dependent instructions.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request to begin an operation; sampled only in IDLE.
- ALU_control  input  4  operation select; 4'b0010 = mult, 4'b0011 = div, any other value is ignored.
- operand_a  input  WIDTH  signed multiplicand / dividend, captured with start.
- operand_b  input  WIDTH  signed multiplier / divisor, captured with start.
- busy  output  1  high while in MUL or DIV state.
- done  output  1  one-cycle pulse; HI/LO are valid from this cycle on.
- div_by_zero  output  1  high together with done when a divide had operand_b == 0.
- hi  output  WIDTH  mult: upper product half; div: remainder.
- lo  output  WIDTH  mult: lower product half; div: quotient.

## Operation
- States: IDLE, MUL, DIV, DONE.
  - IDLE: start=1 with ALU_control=0010 → MUL; with 0011 and operand_b≠0 → DIV; with 0011 and operand_b=0 → DONE.
  - IDLE with start=1 and any other ALU_control → stays IDLE, no effect.
  - MUL/DIV → DONE after exactly WIDTH iterations.
  - DONE → IDLE unconditionally.
- Capture on start (in IDLE): store |operand_a| and |operand_b| as unsigned WIDTH-bit magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1). Also store result sign and dividend sign. Clear the iteration counter (log2(WIDTH)+1 bits) and the 2·WIDTH-bit accumulator.
- MUL iteration:
  - If the multiplier LSB = 1, add the multiplicand into the upper half of the accumulator (carry kept).
  - Shift the accumulator and multiplier right by 1.
- DIV iteration (restoring):
  - Shift {remainder, quotient} left by 1.
  - If remainder ≥ divisor magnitude: subtract the divisor and set quotient LSB = 1.
- On the transition into DONE, load hi/lo:
  - Mult: product, two's-complement negated over 2·WIDTH bits if sign(a) XOR sign(b).
  - Div: quotient negated if the signs differ; remainder takes the dividend's sign (C/MIPS truncation semantics).
  - Divide by zero: lo = all ones, hi = operand_a, div_by_zero = 1.
- hi/lo hold their value until the next completed operation; they are not disturbed during MUL/DIV.
- start asserted while busy or in DONE is ignored; it is not queued.
- Reset, including mid-operation: state = IDLE, counter = 0, hi = lo = 0, busy = done = div_by_zero = 0. The partial result is discarded.

## Timing
- Edge E0 samples start in IDLE. Iterations occur on edges E1..E_WIDTH. Edge E_WIDTH enters DONE and loads hi/lo.
- busy is high in the cycles after E0 up to E_WIDTH, i.e. WIDTH cycles.
- done is high for exactly one cycle after E_WIDTH.
- Start-to-done latency: WIDTH+1 cycles (33 for WIDTH=32).
- Divide by zero: done and div_by_zero are high in the cycle after E0 (latency 1); busy never rises.
- Next start is accepted at edge E_WIDTH+2 at the earliest (first IDLE cycle).
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.

## Structure
- Shared package alu_pkg:
  - ALU_control code constants (ALU_ADD 0000, ALU_SUB 0001, ALU_MULT 0010, ALU_DIV 0011, ALU_SLL 0100, ALU_SRL 0101, ALU_AND 1000, ALU_OR 1001, ALU_XOR 1010, ALU_NOR 1011).
  - muldiv state enum.
- Sub-module muldiv_step: a combinational single-iteration unit. Inputs: mode, accumulator, operand magnitude. Output: next accumulator. The FSM, counter and sign fix-up stay in muldiv_sequencer.

## Test plan
- Mult 7 × -3 (WIDTH=32) → done at 33 cycles; hi=FFFFFFFF, lo=FFFFFFEB; busy high for exactly 32 cycles.
- Mult 80000000 × 80000000 → hi=40000000, lo=00000000; mult FFFFFFFF × 1 → hi=FFFFFFFF, lo=FFFFFFFF.
- Div 7 ÷ -2 → lo=FFFFFFFD, hi=00000001; div -7 ÷ 2 → lo=FFFFFFFD, hi=FFFFFFFF.
- Div 5 ÷ 0 → done and div_by_zero in the next cycle; lo=FFFFFFFF, hi=00000005; busy stays 0.
- start with ALU_control=0000 → no busy, no done, hi/lo unchanged. start pulsed mid-MUL → ignored; result matches the first operands.
- Assert reset at iteration 10 of a divide → all outputs 0 immediately. A following mult 3 × 4 → lo=0000000C, hi=0 at normal latency.
